// File: rtl/mem_rmw_ctrl.sv
// MEM-stage access controller: word stores, sub-word read-modify-write stores with stall,
// lane-selected loads. Define MEM_ALIGN_EXC_EN to enable alignment/range exceptions.
module mem_rmw_ctrl #(
    parameter int DM_BYTES = 12288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] pc,
    input  logic        req,
    input  logic [31:0] dm_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    output logic [31:0] dm_pc,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        exc_adel,
    output logic        exc_ades
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
    } op_e;

    typedef enum logic {S_IDLE, S_MERGE} state_e;

    state_e      state, state_next;
    logic [31:0] merge_q;
    logic [31:0] merged;
    logic [31:0] load_ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
    logic        is_load, is_sub, is_store, addr_err, in_idle;

    if (DM_BYTES < 4) begin : g_bad_size
        $error("DM_BYTES must be at least one word");
    end

    assign is_lw    = (mem_op == OP_LW);
    assign is_lh    = (mem_op == OP_LH);
    assign is_lhu   = (mem_op == OP_LHU);
    assign is_lb    = (mem_op == OP_LB);
    assign is_lbu   = (mem_op == OP_LBU);
    assign is_sw    = (mem_op == OP_SW);
    assign is_sh    = (mem_op == OP_SH);
    assign is_sb    = (mem_op == OP_SB);
    assign is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
    assign is_sub   = is_sh | is_sb;
    assign is_store = is_sw | is_sub;
    assign in_idle  = (state == S_IDLE);

`ifdef MEM_ALIGN_EXC_EN
    logic misaligned, out_of_range;
    assign misaligned   = ((is_lw | is_sw) && (addr[1:0] != 2'b00))
                        || ((is_lh | is_lhu | is_sh) && addr[0]);
    assign out_of_range = (addr >= 32'(DM_BYTES));
    assign addr_err     = (is_load | is_store) && (misaligned || out_of_range);
`else
    assign addr_err = 1'b0;
`endif

    assign dm_addr = {addr[31:2], 2'b00};
    assign dm_pc   = pc;
    assign lane_b  = dm_rdata[{addr[1:0], 3'b000} +: 8];
    assign lane_h  = dm_rdata[{addr[1], 4'b0000} +: 16];

    // Upstream holds mem_op/addr/store_data during the stall, so MERGE can reuse them.
    always_comb begin
        merged = merge_q;
        if (is_sb)
            merged[{addr[1:0], 3'b000} +: 8] = store_data[7:0];
        else if (is_sh)
            merged[{addr[1], 4'b0000} +: 16] = store_data[15:0];
    end

    always_comb begin
        case (mem_op)
            OP_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_ext = {16'h0000, lane_h};
            OP_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_ext = {24'h000000, lane_b};
            default: load_ext = dm_rdata;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_next = state;
        dm_we      = 1'b0;
        dm_wd      = store_data;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!addr_err && !req) begin
                    if (is_sw) begin
                        dm_we = 1'b1;
                    end else if (is_sub) begin
                        stall      = 1'b1;
                        state_next = S_MERGE;
                    end
                end
            end
            S_MERGE: begin
                dm_we      = !req;
                dm_wd      = merged;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            merge_q    <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            state      <= state_next;
            load_valid <= in_idle && is_load && !addr_err;
            if (in_idle && state_next == S_MERGE)
                merge_q <= dm_rdata;
            if (in_idle && is_load && !addr_err)
                load_data <= load_ext;
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
        end else begin
            exc_adel <= in_idle && is_load && addr_err;
            exc_ades <= in_idle && is_store && addr_err;
        end
    end
`else
    assign exc_adel = 1'b0;
    assign exc_ades = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: byte-level memory model, per-cycle compare process,
// plus literal expectations from hand-worked examples.
module tb_mem_rmw_ctrl;

    localparam int DM_BYTES = 12288;
    localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4,
                           LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mem_op;
    logic [31:0] addr, store_data, pc, dm_rdata;
    logic        req;
    logic [31:0] dm_addr, dm_wd, dm_pc, load_data;
    logic        dm_we, stall, load_valid, exc_adel, exc_ades;

    mem_rmw_ctrl #(.DM_BYTES(DM_BYTES)) dut (
        .clk(clk), .reset(reset), .mem_op(mem_op), .addr(addr), .store_data(store_data),
        .pc(pc), .req(req), .dm_rdata(dm_rdata), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_we(dm_we), .dm_pc(dm_pc), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem [0:4095];
    assign dm_rdata = dmem[dm_addr[13:2]];
    always @(posedge clk) if (dm_we) dmem[dm_addr[13:2]] <= dm_wd;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;
    logic        exp_stall = 1'b0, exp_we = 1'b0, exp_lv = 1'b0, exp_adel = 1'b0, exp_ades = 1'b0;
    logic [31:0] exp_wd = '0, exp_ld = '0;
    logic [7:0]  sm [int];
    logic [31:0] pc_ctr = 32'h0040_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int op_width(input logic [3:0] op);
        case (op)
            LW, SW:      return 4;
            LH, LHU, SH: return 2;
            LB, LBU, SB: return 1;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_byte(input int a);
        return sm.exists(a) ? sm[a] : 8'h00;
    endfunction

    function automatic bit model_err(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_EXC_EN
        int w = op_width(op);
        if (w == 0) return 1'b0;
        if (a >= DM_BYTES) return 1'b1;
        return (a % w) != 0;
`else
        return (op == 4'hF) && (a == 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a);
        int w = op_width(op);
        int base = int'(a) - int'(a % w);
        logic [63:0] v = 0;
        for (int i = 0; i < w; i++) v = v + (64'(model_byte(base + i)) << (8 * i));
        if ((op == LB || op == LH) && v[8 * w - 1]) v = v - (64'd1 << (8 * w));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base = int'(a) - int'(a % 4);
        return {model_byte(base + 3), model_byte(base + 2), model_byte(base + 1), model_byte(base)};
    endfunction

    task automatic apply_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        int w = op_width(op);
        int base = int'(a) - int'(a % w);
        for (int i = 0; i < w; i++) sm[base + i] = d[8 * i +: 8];
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", stall, exp_stall);
            check("dm_we", dm_we, exp_we);
            if (exp_we) check("dm_wd", dm_wd, exp_wd);
            check("dm_addr", dm_addr, addr & ~32'h3);
            check("dm_pc", dm_pc, pc);
            check("load_valid", load_valid, exp_lv);
            if (exp_lv) check("load_data", load_data, exp_ld);
            check("exc_adel", exc_adel, exp_adel);
            check("exc_ades", exc_ades, exp_ades);
        end
    end

    task automatic clear_reg_exp();
        exp_lv = 1'b0; exp_adel = 1'b0; exp_ades = 1'b0;
    endtask

    // Issues one operation; returns 1 time unit after the edge that completes it.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit rq1 = 1'b0, input bit rq2 = 1'b0);
        bit err    = model_err(op, a);
        bit is_ld  = (op inside {LW, LH, LHU, LB, LBU});
        bit is_sub = (op inside {SH, SB});
        bit is_st  = is_sub || (op == SW);
        pc_ctr    = pc_ctr + 4;
        mem_op    = op; addr = a; store_data = d; pc = pc_ctr; req = rq1;
        exp_stall = is_sub && !err && !rq1;
        exp_we    = (op == SW) && !err && !rq1;
        exp_wd    = d;
        @(posedge clk);
        if (exp_we) apply_store(op, a, d);
        exp_lv   = is_ld && !err;
        if (exp_lv) exp_ld = model_load(op, a);
        exp_adel = is_ld && err;
        exp_ades = is_st && err;
        #1;
        if (exp_stall) begin
            req       = rq2;
            exp_stall = 1'b0;
            exp_we    = !rq2;
            if (!rq2) begin
                apply_store(op, a, d);
                exp_wd = model_word(a);
            end
            @(posedge clk);
            clear_reg_exp();
            #1;
        end
        mem_op = NONE; req = 1'b0; exp_stall = 1'b0; exp_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) dmem[i] = '0;
        reset = 1'b0; mem_op = NONE; addr = '0; store_data = '0; pc = '0; req = 1'b0;
        #12;
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_adel", exc_adel, 1'b0);
        check("rst_ades", exc_ades, 1'b0);
        check("rst_we", dm_we, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1'b1;

        // Word store then load
        do_op(SW, 32'h10, 32'h1234_5678);
        check("pin_sw_mem", dmem[4], 32'h1234_5678);
        do_op(LW, 32'h10, 32'h0);
        check("pin_lw", load_data, 32'h1234_5678);

        // Byte read-modify-write and byte loads
        do_op(SB, 32'h12, 32'hFFFF_FFAB);
        check("pin_sb_mem", dmem[4], 32'h12AB_5678);
        do_op(LB, 32'h12, 32'h0);
        check("pin_lb", load_data, 32'hFFFF_FFAB);
        do_op(LBU, 32'h12, 32'h0);
        check("pin_lbu", load_data, 32'h0000_00AB);

        // Halfword read-modify-write and half loads
        do_op(SH, 32'h12, 32'h0000_8001);
        check("pin_sh_mem", dmem[4], 32'h8001_5678);
        do_op(LH, 32'h12, 32'h0);
        check("pin_lh", load_data, 32'hFFFF_8001);
        do_op(LHU, 32'h12, 32'h0);
        check("pin_lhu", load_data, 32'h0000_8001);
        do_op(LB, 32'h13, 32'h0);
        check("pin_lb_b3", load_data, 32'hFFFF_FF80);
        do_op(LH, 32'h10, 32'h0);
        check("pin_lh_h0", load_data, 32'h0000_5678);
        do_op(4'd12, 32'h10, 32'h0);

`ifdef MEM_ALIGN_EXC_EN
        do_op(LW, 32'h11, 32'h0);
        check("pin_adel", exc_adel, 1'b1);
        check("pin_adel_lv", load_valid, 1'b0);
        do_op(SH, 32'h13, 32'h0000_BEEF);
        check("pin_ades_sh", exc_ades, 1'b1);
        check("pin_sh_nowrite", dmem[4], 32'h8001_5678);
        do_op(SW, 32'h3000, 32'h0BAD_F00D);
        check("pin_ades_range", exc_ades, 1'b1);
        check("pin_range_nowrite", dmem[3072], 32'h0);
        do_op(LB, 32'h3000, 32'h0);
        check("pin_adel_range", exc_adel, 1'b1);
`else
        do_op(LW, 32'h11, 32'h0);
        check("pin_lw_unaligned", load_data, 32'h8001_5678);
        check("pin_adel_tied", exc_adel, 1'b0);
        do_op(SH, 32'h13, 32'h0000_BEEF);
        check("pin_sh_unaligned", dmem[4], 32'hBEEF_5678);
        do_op(SW, 32'h3000, 32'h0BAD_F00D);
        check("pin_sw_range", dmem[3072], 32'h0BAD_F00D);
        check("pin_ades_tied", exc_ades, 1'b0);
`endif

        // req in IDLE: stores suppressed, loads still complete
        do_op(SW, 32'h20, 32'hDEAD_BEEF, 1'b1);
        check("pin_req_sw", dmem[8], 32'h0);
        do_op(SW, 32'h20, 32'hCAFE_F00D);
        do_op(LW, 32'h20, 32'h0, 1'b1);
        check("pin_req_lw", load_data, 32'hCAFE_F00D);
        do_op(SB, 32'h21, 32'h55, 1'b1);
        check("pin_req_sb_idle", dmem[8], 32'hCAFE_F00D);

        // req in MERGE: write dropped
        do_op(SB, 32'h21, 32'h55, 1'b0, 1'b1);
        check("pin_req_merge", dmem[8], 32'hCAFE_F00D);
        check("pin_req_merge_stall", stall, 1'b0);
        do_op(SB, 32'h21, 32'h55);
        check("pin_sb_b1", dmem[8], 32'hCAFE_550D);

        // Reset in the middle of MERGE
        do_op(SW, 32'h40, 32'h1122_3344);
        do_op(LW, 32'h40, 32'h0);
        mem_op = SB; addr = 32'h41; store_data = 32'hEE; req = 1'b0;
        exp_stall = 1'b1; exp_we = 1'b0;
        @(posedge clk);
        clear_reg_exp();
        #1;
        cmp_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("rst_mid_we", dm_we, 1'b0);
        check("rst_mid_load_data", load_data, 32'h0);
        check("rst_mid_lv", load_valid, 1'b0);
        check("rst_mid_adel", exc_adel, 1'b0);
        check("rst_mid_ades", exc_ades, 1'b0);
        mem_op = NONE; exp_stall = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_mem", dmem[16], 32'h1122_3344);
        cmp_en = 1'b1;
        do_op(LBU, 32'h41, 32'h0);
        check("pin_after_rst", load_data, 32'h0000_0033);

        @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_rmw_ctrl.md
# mem_rmw_ctrl

Memory-stage access controller that sits between the EX/MEM pipeline register and the word-wide data memory. It feeds the memory its word address, write data, write enable and PC, and consumes the memory's combinational read data. Sub-word stores (SB/SH) become a two-cycle read-modify-write with a pipeline stall. Loads are lane-selected, extended and registered toward WB, and misaligned or out-of-range accesses are flagged.

## Interface
Parameters:
- `DM_BYTES`, 12288: size of the data memory in bytes; a byte address is valid when it is below `DM_BYTES`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `mem_op` in 4: 0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; codes 9–15 are treated as NONE.
- `addr` in 32: byte address from ALU.
- `store_data` in 32: rt value; low byte or halfword is used for SB/SH.
- `pc` in 32: PC of the instruction in MEM.
- `req` in 1: interrupt/flush request; suppresses any write this cycle.
- `dm_rdata` in 32: combinational read word from data memory.
- `dm_addr` out 32: `{addr[31:2], 2'b00}`.
- `dm_wd` out 32: word to write.
- `dm_we` out 1: memory write enable.
- `dm_pc` out 32: PC forwarded for memory trace.
- `stall` out 1: freeze IF/ID/EX and the EX/MEM register.
- `load_data` out 32: extended load result (registered).
- `load_valid` out 1: one-cycle pulse, `load_data` valid.
- `exc_adel` out 1: load address error (registered pulse).
- `exc_ades` out 1: store address error (registered pulse).

## Operation
- FSM states:
  - IDLE:
    - SW: `dm_we`=1, `dm_wd`=`store_data`, stall=0.
    - SB/SH: `dm_we`=0, `stall`=1; the edge captures `dm_rdata` into `merge_q` and the FSM goes to MERGE.
    - Loads: `dm_we`=0; the edge registers the extended result and sets `load_valid`=1.
  - MERGE: `dm_we`=!`req`, `dm_wd`=`merge_q` with the addressed lane replaced, `stall`=0, then back to IDLE.
- Lane rules (little-endian, byte 0 = bits 7:0):
  - SB replaces byte `addr[1:0]` with `store_data[7:0]`.
  - SH replaces half `addr[1]` with `store_data[15:0]`.
  - LB/LBU select byte `addr[1:0]`, sign/zero extend.
  - LH/LHU select half `addr[1]`, sign/zero extend.
- Error conditions:
  - Misaligned: LW/SW with `addr[1:0]`≠0; LH/LHU/SH with `addr[0]`≠0.
  - Out of range: `addr` ≥ `DM_BYTES`.
  - Either condition gives no write, no stall, no `load_valid`. The matching `exc_adel`/`exc_ades` pulses on the next cycle.
- `req`=1 in IDLE: no write, no stall, no FSM transition; loads still complete.
- `req`=1 in MERGE: write dropped, return to IDLE; `stall` is already 0, so the instruction leaves MEM.
- `dm_addr`, `dm_wd`, `dm_we`, `dm_pc` and `stall` are combinational from state and inputs. Upstream holds `mem_op`/`addr`/`store_data`/`pc` stable while `stall`=1.

## Timing
- Reset (asynchronous assert, synchronous release via clock):
  - state=IDLE, `merge_q`=0.
  - `load_data`=0, `load_valid`=0, `exc_adel`=0, `exc_ades`=0.
  - Combinational outputs follow inputs, with state=IDLE.
- SW: write on the edge ending the issue cycle; latency 1, no stall.
- SB/SH: 2 cycles.
  - Cycle 1: read, `stall`=1.
  - Cycle 2: write lands on the edge ending MERGE; the pipeline advances on that same edge.
- Loads: `load_data`/`load_valid` valid the cycle after issue; latency 1.
- Back-to-back store then load to the same word needs no forwarding; the write completes before the next cycle's combinational read.
- Reset mid-MERGE: the FSM returns to IDLE immediately and the write is lost.

## Configuration
- `MEM_ALIGN_EXC_EN`:
  - Defined: misalignment and range checks as above.
  - Undefined: `exc_adel`/`exc_ades` are tied 0. Low address bits are ignored for alignment: LW/SW use the word, LH/SH use half `addr[1]`. Out-of-range accesses proceed unchecked.

## Test plan
- Reset: `reset`=0 mid-MERGE → state IDLE, `dm_we`=0, `load_data`=0, all pulses 0 immediately.
- SW then LW: SW addr 0x10 data 0x12345678 → `dm_we`=1 one cycle, no stall. LW 0x10 next → `load_data`=0x12345678, `load_valid`=1 the following cycle.
- SB RMW: word 0x10 = 0x12345678; SB addr 0x12 data 0xAB → `stall`=1 for 1 cycle, then `dm_wd`=0x12AB5678, `dm_we`=1. LB 0x12 → 0xFFFFFFAB; LBU 0x12 → 0x000000AB.
- SH RMW: SH addr 0x12 data 0x8001 → word 0x80015678. LH 0x12 → 0xFFFF8001; LHU → 0x00008001.
- Errors (macro defined):
  - LW 0x11 → `exc_adel`=1 next cycle, `load_valid`=0.
  - SH 0x13 → `exc_ades`=1, no write, no stall.
  - SW 0x3000 → `exc_ades`=1.
- `req` in MERGE: SB 0x20 with `req`=1 on cycle 2 → `dm_we`=0, word unchanged, FSM back to IDLE, `stall`=0.
